io_uart_responder: RTL

- Memory-mapped UART peripheral that sits on the responder end of the core's IO interface (io_address / io_write_value / io_read_value / io_write_en / io_read_en / io_data_size).
- The core is single-cycle, so reads are combinational in the same cycle and writes and read side effects commit on posedge clk.
- Contains a TX FIFO feeding a serializer, and an RX deserializer with a one-byte holding register.

---
 rtl/io_uart_responder_pkg.sv | 25 ++
 rtl/io_uart_responder_if.sv | 21 ++
 rtl/io_uart_responder_tx_fifo.sv | 47 ++++
 rtl/io_uart_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_responder_pkg.sv
// Shared constants for the IO-mapped UART: register offsets, STATUS bit
// positions and the 2-bit state encoding used by both serial FSMs.
package io_uart_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;

  localparam int ST_TX_EMPTY  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_TX_OVF    = 5;
  localparam int ST_RX_FERR   = 6;
  localparam int ST_TX_CNT_LO = 8;   // tx_count occupies [11:8]

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/io_uart_responder_if.sv
// Core IO bus as seen by a memory-mapped responder.
//   master : the core (drives address/data/strobes, receives read data)
//   slave  : the peripheral (returns combinational read data)
interface io_uart_responder_if;
  logic [31:0] io_address;
  logic [31:0] io_write_value;
  logic [31:0] io_read_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [2:0]  io_data_size;

  modport master (
    output io_address, io_write_value, io_write_en, io_read_en, io_data_size,
    input  io_read_value
  );

  modport slave (
    input  io_address, io_write_value, io_write_en, io_read_en, io_data_size,
    output io_read_value
  );
endinterface

// File: rtl/io_uart_responder_tx_fifo.sv
// Synchronous FIFO feeding the UART serializer.
//   push/din  : write one entry (caller guarantees space, or a same-cycle pop)
//   pop/dout  : dout shows the head; pop advances it (caller guarantees !empty)
//   full/empty/count : occupancy, count is one bit wider than the pointers
module io_uart_tx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/io_uart_responder.sv
// Memory-mapped UART responder on the core IO bus.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : IO bus slave port (reads combinational, writes at posedge)
//   uart_tx    : serial out, idles high
//   uart_rx    : serial in, asynchronous (2-flop synchronized)
// Registers: 0x0 DATA (W: push TX byte, R: pop RX byte), 0x4 STATUS
// (R: flags, W1C sticky errors), 0x8 DIVISOR (clock cycles per bit).
module io_uart_responder
  import io_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          TX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic                     clk,
  input  logic                     rst_n,
  io_uart_responder_if.slave       bus,
  output logic                     uart_tx,
  input  logic                     uart_rx
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic        sel;
  logic [3:0]  off;
  logic        wr_data, wr_stat, wr_div, rd_data;
  logic [15:0] divisor, div_eff, half_div;
  logic        tx_overflow, rx_overrun, rx_frame_err, rx_valid;
  logic [7:0]  rx_data;

  assign sel     = (bus.io_address[31:4] == BASE_ADDR[31:4]);
  assign off     = bus.io_address[3:0];
  assign wr_data = sel && bus.io_write_en && (off == OFF_DATA);
  assign wr_stat = sel && bus.io_write_en && (off == OFF_STATUS);
  assign wr_div  = sel && bus.io_write_en && (off == OFF_DIV);
  assign rd_data = sel && bus.io_read_en  && (off == OFF_DATA);

  // Access size is irrelevant: every register lives in the low bits.
  logic unused_bits;
  assign unused_bits = ^{bus.io_data_size, bus.io_write_value[31:16]};

  // A divisor of 0 runs like 1; the RX start-bit wait is never shorter than 1.
  assign div_eff  = (divisor == 16'd0) ? 16'd1 : divisor;
  assign half_div = (divisor[15:1] == 15'd0) ? 16'd1 : {1'b0, divisor[15:1]};

  // ---------------- TX FIFO ----------------
  logic          f_full, f_empty, tx_pop, push_ok;
  logic [7:0]    f_dout;
  logic [CW-1:0] f_count;

  // A full FIFO still takes a byte when the serializer drains one this cycle.
  assign push_ok = wr_data && (!f_full || tx_pop);

  io_uart_tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .din   (bus.io_write_value[7:0]),
    .pop   (tx_pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // ---------------- TX serializer ----------------
  uart_state_e tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_byte;

  // Pop from idle, or at the last cycle of STOP for a gapless next frame.
  assign tx_pop = !f_empty &&
                  ((tx_state == S_IDLE) || ((tx_state == S_STOP) && (tx_cnt == 16'd0)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      uart_tx  <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= S_START;
      tx_byte  <= f_dout;
      tx_cnt   <= div_eff - 16'd1;
      uart_tx  <= 1'b0;
    end else begin
      case (tx_state)
        S_START:
          if (tx_cnt == 16'd0) begin
            tx_state <= S_DATA;
            tx_bit   <= '0;
            tx_cnt   <= div_eff - 16'd1;
            uart_tx  <= tx_byte[0];
          end else tx_cnt <= tx_cnt - 16'd1;
        S_DATA:
          if (tx_cnt == 16'd0) begin
            tx_cnt <= div_eff - 16'd1;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              uart_tx <= tx_byte[tx_bit + 3'd1];
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        S_STOP:
          if (tx_cnt == 16'd0) tx_state <= S_IDLE;
          else                 tx_cnt   <= tx_cnt - 16'd1;
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX deserializer ----------------
  logic        rx_meta, rx_sync;
  uart_state_e rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_done;

  assign rx_done = (rx_state == S_STOP) && (rx_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      case (rx_state)
        S_IDLE:
          if (!rx_sync) begin
            rx_state <= S_START;
            rx_cnt   <= half_div - 16'd1;
          end
        S_START:
          // Re-check the line mid start bit; a high level means a glitch.
          if (rx_cnt == 16'd0) begin
            if (rx_sync) rx_state <= S_IDLE;
            else begin
              rx_state <= S_DATA;
              rx_bit   <= '0;
              rx_cnt   <= div_eff - 16'd1;
            end
          end else rx_cnt <= rx_cnt - 16'd1;
        S_DATA:
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};   // LSB arrives first
            rx_cnt   <= div_eff - 16'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        S_STOP:
          if (rx_cnt == 16'd0) rx_state <= S_IDLE;
          else                 rx_cnt   <= rx_cnt - 16'd1;
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- Registers and sticky flags ----------------
  // Set conditions follow the clears so an error in the same cycle survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divisor      <= DEFAULT_DIV;
      tx_overflow  <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
    end else begin
      if (wr_div) divisor <= bus.io_write_value[15:0];
      if (wr_stat) begin
        if (bus.io_write_value[ST_RX_OVR])  rx_overrun   <= 1'b0;
        if (bus.io_write_value[ST_TX_OVF])  tx_overflow  <= 1'b0;
        if (bus.io_write_value[ST_RX_FERR]) rx_frame_err <= 1'b0;
      end
      if (wr_data && !push_ok) tx_overflow <= 1'b1;
      if (rd_data) rx_valid <= 1'b0;
      if (rx_done) begin
        if (!rx_sync) rx_frame_err <= 1'b1;
        else if (!rx_valid || rd_data) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else rx_overrun <= 1'b1;
      end
    end
  end

  // ---------------- Read mux ----------------
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (sel && bus.io_read_en) begin
      case (off)
        OFF_DATA: rdata[7:0] = rx_data;
        OFF_STATUS: begin
          rdata[ST_TX_EMPTY] = f_empty;
          rdata[ST_TX_FULL]  = f_full;
          rdata[ST_RX_VALID] = rx_valid;
          rdata[ST_RX_OVR]   = rx_overrun;
          rdata[ST_TX_BUSY]  = (tx_state != S_IDLE);
          rdata[ST_TX_OVF]   = tx_overflow;
          rdata[ST_RX_FERR]  = rx_frame_err;
          rdata[ST_TX_CNT_LO +: 4] = 4'(f_count);
        end
        OFF_DIV: rdata[15:0] = divisor;
        default: rdata = '0;
      endcase
    end
  end

  assign bus.io_read_value = rdata;

endmodule
